// File: rtl/logic_slice_sequencer.sv
// logic_slice_sequencer: evaluates one WIDTH-bit bitwise logic operation
// (AND/OR/XOR/NAND) by stepping a shared SLICE-bit gate slice across the
// operands, least-significant slice first, under a start/busy/done handshake.
// Optional feature macro: LOGIC_SEQ_ZERO_FLAG_EN adds a registered zero flag
// built from a per-slice sticky accumulator.
module logic_slice_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned NUM_SLICES = WIDTH / SLICE;
  localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;

  // Reject illegal slicing at elaboration time
  generate
    if ((SLICE == 0) || (WIDTH % SLICE != 0)) begin : g_bad_slice
      $error("logic_slice_sequencer: WIDTH must be a non-zero multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shadow;

  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [1:0]       w_op_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_result_nxt;

  logic [31:0]      w_shift;
  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_res_sl;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_shadow_upd;

`ifdef LOGIC_SEQ_ZERO_FLAG_EN
  logic             r_any;
  logic             w_any_nxt;
  logic             w_any_upd;
  logic             w_zero_nxt;
`endif

  // Bit offset of the slice currently being processed
  assign w_shift = 32'(r_cnt) * 32'(SLICE);

  // Select the active operand slices by shifting them down to bit 0
  assign w_a_sl = SLICE'(r_a >> w_shift);
  assign w_b_sl = SLICE'(r_b >> w_shift);

  // The shared SLICE-bit logic slice; NAND is the inverse of the slice AND
  always_comb begin
    w_res_sl = '0;
    case (r_op)
      OP_AND:  w_res_sl = w_a_sl & w_b_sl;
      OP_OR:   w_res_sl = w_a_sl | w_b_sl;
      OP_XOR:  w_res_sl = w_a_sl ^ w_b_sl;
      default: w_res_sl = ~(w_a_sl & w_b_sl);
    endcase
  end

  // Merge the freshly computed slice into the shadow result
  assign w_mask       = WIDTH'({SLICE{1'b1}}) << w_shift;
  assign w_shadow_upd = (r_shadow & ~w_mask) | (WIDTH'(w_res_sl) << w_shift);

`ifdef LOGIC_SEQ_ZERO_FLAG_EN
  // Sticky "some result bit is set" accumulator, one slice at a time
  assign w_any_upd = r_any | (|w_res_sl);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-register-value logic
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_op_nxt     = r_op;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_busy_nxt   = busy;
    w_done_nxt   = 1'b0;
    w_result_nxt = result;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    w_any_nxt    = r_any;
    w_zero_nxt   = zero;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_RUN;
          w_a_nxt      = a;
          w_b_nxt      = b;
          w_op_nxt     = op;
          w_cnt_nxt    = '0;
          w_shadow_nxt = '0;
          w_busy_nxt   = 1'b1;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
          w_any_nxt    = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        w_shadow_nxt = w_shadow_upd;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        w_any_nxt    = w_any_upd;
`endif
        if (r_cnt == LAST_CNT) begin
          // Last slice: publish the full result as FINISH begins
          w_state_nxt  = ST_FINISH;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_result_nxt = w_shadow_upd;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
          w_zero_nxt   = ~w_any_upd;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_FINISH: begin
        // start is deliberately ignored here
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
      r_any    <= 1'b0;
      zero     <= 1'b0;
`endif
    end else begin
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_op     <= w_op_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
      result   <= w_result_nxt;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
      r_any    <= w_any_nxt;
      zero     <= w_zero_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_logic_slice_sequencer.sv
// Self-checking bench for logic_slice_sequencer: default SLICE=8 instance plus
// SLICE=1 and SLICE=32 instances; expected results travel through a queue.
module tb_logic_slice_sequencer;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_m, start_1, start_32;
  logic [1:0]  op;
  logic [31:0] a, b;

  logic        busy_m, done_m, busy_1, done_1, busy_32, done_32;
  logic [31:0] res_m, res_1, res_32;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
  logic        zero_m, zero_1, zero_32;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  logic_slice_sequencer #(.WIDTH(32), .SLICE(8)) u_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .op(op), .a(a), .b(b),
    .busy(busy_m), .done(done_m), .result(res_m)
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    , .zero(zero_m)
`endif
  );

  logic_slice_sequencer #(.WIDTH(32), .SLICE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_1), .op(op), .a(a), .b(b),
    .busy(busy_1), .done(done_1), .result(res_1)
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    , .zero(zero_1)
`endif
  );

  logic_slice_sequencer #(.WIDTH(32), .SLICE(32)) u_s32 (
    .clk(clk), .rst_n(rst_n), .start(start_32), .op(op), .a(a), .b(b),
    .busy(busy_32), .done(done_32), .result(res_32)
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    , .zero(zero_32)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int inst);
    case (inst)
      0:       return busy_m;
      1:       return busy_1;
      default: return busy_32;
    endcase
  endfunction

  function automatic logic get_done(input int inst);
    case (inst)
      0:       return done_m;
      1:       return done_1;
      default: return done_32;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int inst);
    case (inst)
      0:       return res_m;
      1:       return res_1;
      default: return res_32;
    endcase
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0:       start_m  = v;
      1:       start_1  = v;
      default: start_32 = v;
    endcase
  endtask

  // Bitwise reference for randomly generated vectors
  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // Pop the oldest expected result and compare it with what the DUT produced
  task automatic sb_check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      chk(name, act, exp);
    end
  endtask

  // One complete operation on instance inst, with latency/busy/hold checks
  task automatic run_op(input int inst, input logic [1:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp);
    int          n;
    int          lat;
    int          busy_cnt;
    logic        held;
    logic [31:0] prev;
    n        = (inst == 0) ? 4 : ((inst == 1) ? 32 : 1);
    lat      = 0;
    busy_cnt = 0;
    held     = 1'b1;
    prev     = get_res(inst);
    @(negedge clk);
    op = o; a = va; b = vb;
    set_start(inst, 1'b1);
    sb_q.push_back(exp);
    @(negedge clk);
    set_start(inst, 1'b0);
    for (int cyc = 1; cyc <= n + 8; cyc++) begin
      if (get_done(inst)) begin
        lat = cyc;
        break;
      end
      if (get_busy(inst)) busy_cnt++;
      if (get_res(inst) !== prev) held = 1'b0;
      @(negedge clk);
    end
    if (lat == 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else begin
      chk("latency_cycles", 32'(lat), 32'(n + 1));
      chk("busy_cycles", 32'(busy_cnt), 32'(n));
      chk("busy_in_done_cycle", 32'(get_busy(inst)), 32'd0);
      chk("result_stable_while_running", 32'(held), 32'd1);
      sb_check("result", get_res(inst));
      @(negedge clk);
      chk("done_single_pulse", 32'(get_done(inst)), 32'd0);
      chk("result_hold_after_done", get_res(inst), exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          done_cnt;
    int          first_done;
    int          lat;
    logic        held;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0] = '{OP_AND,  32'hF0F0_1234, 32'hFF00_00FF, 32'hF000_0034};
    vecs[1] = '{OP_OR,   32'hF0F0_1234, 32'hFF00_00FF, 32'hFFF0_12FF};
    vecs[2] = '{OP_XOR,  32'hF0F0_1234, 32'hFF00_00FF, 32'h0FF0_12CB};
    vecs[3] = '{OP_NAND, 32'hF0F0_1234, 32'hFF00_00FF, 32'h0FFF_FFCB};
    vecs[4] = '{OP_AND,  32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
    vecs[5] = '{OP_XOR,  32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[6] = '{OP_NAND, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[7] = '{OP_OR,   32'h8000_0001, 32'h0000_0000, 32'h8000_0001};

    rst_n = 1'b0; start_m = 1'b0; start_1 = 1'b0; start_32 = 1'b0;
    op = OP_AND; a = '0; b = '0;

    // Reset values
    #1;
    chk("reset_busy", 32'(busy_m), 32'd0);
    chk("reset_done", 32'(done_m), 32'd0);
    chk("reset_result", res_m, 32'd0);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    chk("reset_zero", 32'(zero_m), 32'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_result", res_m, 32'd0);

    // Table-driven vectors on the default instance
    foreach (vecs[i]) run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // A few random vectors
    for (int i = 0; i < 3; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      run_op(0, ro, ra, rb, ref_op(ro, ra, rb));
    end

    // start held high and operands scrambled during RUN
    done_cnt = 0;
    first_done = 0;
    @(negedge clk);
    op = OP_AND; a = 32'hF0F0_1234; b = 32'hFF00_00FF; start_m = 1'b1;
    sb_q.push_back(32'hF000_0034);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (done_m) begin
        done_cnt++;
        if (first_done == 0) begin
          first_done = cyc;
          sb_check("hold_start_result", res_m);
        end
      end
      if (cyc < 5) begin
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      end else if (cyc == 5) begin
        op = OP_XOR; a = 32'h1234_5678; b = 32'hFFFF_0000;
      end
      if (cyc == 6) chk("hold_start_idle_gap_busy", 32'(busy_m), 32'd0);
    end
    chk("hold_start_done_count", 32'(done_cnt), 32'd1);
    chk("hold_start_done_cycle", 32'(first_done), 32'd5);
    @(negedge clk);
    chk("hold_start_reaccept_busy", 32'(busy_m), 32'd1);
    start_m = 1'b0;
    sb_q.push_back(32'hEDCB_5678);
    lat = 0;
    held = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (done_m) begin
        lat = cyc;
        break;
      end
      if (res_m !== 32'hF000_0034) held = 1'b0;
    end
    chk("second_op_done_seen", 32'(lat), 32'd4);
    chk("second_op_prev_result_held", 32'(held), 32'd1);
    sb_check("second_op_result", res_m);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    @(negedge clk);
    op = OP_AND; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    @(negedge clk);
    chk("midop_busy_before_reset", 32'(busy_m), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midop_reset_busy", 32'(busy_m), 32'd0);
    chk("midop_reset_done", 32'(done_m), 32'd0);
    chk("midop_reset_result", res_m, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (done_m || busy_m) done_cnt++;
    end
    chk("midop_abandoned_no_activity", 32'(done_cnt), 32'd0);
    run_op(0, OP_AND, 32'h0000_0001, 32'h0000_0003, 32'h0000_0001);

`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    // Zero flag
    run_op(0, OP_AND, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000);
    chk("zero_flag_set", 32'(zero_m), 32'd1);
    run_op(0, OP_OR, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF);
    chk("zero_flag_clear", 32'(zero_m), 32'd0);
`endif

    // Narrowest and widest slice instances
    run_op(1, OP_XOR,  32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF);
    run_op(2, OP_XOR,  32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF);
    run_op(1, OP_NAND, 32'hF0F0_1234, 32'hFF00_00FF, 32'h0FFF_FFCB);
    run_op(2, OP_AND,  32'hF0F0_1234, 32'hFF00_00FF, 32'hF000_0034);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
